// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared constants and types for the pipelined 256-to-8 lowest-set-bit encoder.
//   IN_W   : total input width (power of two, multiple of GRP_W)
//   OUT_W  : index width, log2(IN_W)
//   GRP_W  : width of one stage-1 group (power of two)
//   N_GRP  : number of groups the input word is split into
//   GIDX_W : width of a group index
//   LIDX_W : width of a bit index inside one group
//   grp_res_t : per-group result {any, mul, lidx}
// -----------------------------------------------------------------------------
package enc_pkg;

  localparam int IN_W   = 256;
  localparam int OUT_W  = 8;
  localparam int GRP_W  = 16;
  localparam int N_GRP  = IN_W / GRP_W;
  localparam int GIDX_W = $clog2(N_GRP);
  localparam int LIDX_W = $clog2(GRP_W);

  typedef struct packed {
    logic              any;   // at least one bit set in the group
    logic              mul;   // two or more bits set in the group
    logic [LIDX_W-1:0] lidx;  // lowest set bit, 0 when the group is empty
  } grp_res_t;

endpackage

// File: rtl/enc_pipe_if.sv
// -----------------------------------------------------------------------------
// enc_pipe_if
// Valid/ready bundle around the encoder.
//   in_valid/in_ready   : input handshake
//   in0/in1             : input word, bits [127:0] and [255:128]
//   out_valid/out_ready : output handshake
//   out0                : index of the lowest set bit
//   zero/multi          : no bit set / two or more bits set
// Modports: master drives the input side and consumes results,
//           slave is the encoder view.
// -----------------------------------------------------------------------------
interface enc_pipe_if;
  import enc_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [IN_W/2-1:0]   in0;
  logic [IN_W/2-1:0]   in1;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out0;
  logic                zero;
  logic                multi;

  modport master (
    output in_valid, in0, in1, out_ready,
    input  in_ready, out_valid, out0, zero, multi
  );

  modport slave (
    input  in_valid, in0, in1, out_ready,
    output in_ready, out_valid, out0, zero, multi
  );

endinterface

// File: rtl/enc_grp.sv
// -----------------------------------------------------------------------------
// enc_grp
// Combinational GRP_W-to-LIDX_W priority encoder for one group.
//   i_bits : group input bits
//   o_res  : {any, mul, lidx}; lidx is the lowest set bit (0 when empty)
// -----------------------------------------------------------------------------
module enc_grp
  import enc_pkg::*;
(
  input  logic [GRP_W-1:0] i_bits,
  output grp_res_t         o_res
);

  logic [LIDX_W-1:0] w_lidx;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    w_lidx = '0;
    for (int i = GRP_W - 1; i >= 0; i--) begin
      if (i_bits[i]) w_lidx = LIDX_W'(i);
    end
  end

  assign o_res.any  = |i_bits;
  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign o_res.mul  = |(i_bits & (i_bits - GRP_W'(1)));
  assign o_res.lidx = w_lidx;

endmodule

// File: rtl/enc_pipe.sv
// -----------------------------------------------------------------------------
// enc_pipe
// Two-stage pipelined 256-to-8 encoder returning the index of the lowest set
// bit, with flags for an all-zero word and for a word that is not one-hot.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : enc_pipe_if.slave (input/output valid-ready handshake and data)
// Stage 1 registers per-group priority-encoder results; stage 2 picks the
// lowest non-empty group and registers out0/zero/multi. Both stages advance
// together whenever the output register is empty or being drained.
// -----------------------------------------------------------------------------
module enc_pipe
  import enc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  enc_pipe_if.slave bus
);

  logic                    w_adv;
  logic [IN_W-1:0]         w_word;
  grp_res_t                w_res [N_GRP];

  logic                    r_vld_p1;
  logic [N_GRP-1:0]        r_any_p1;
  logic [N_GRP-1:0]        r_mul_p1;
  logic [LIDX_W-1:0]       r_lidx_p1 [N_GRP];

  logic [GIDX_W-1:0]       w_gsel;
  logic                    w_zero;
  logic                    w_multi;
  logic [OUT_W-1:0]        w_out0;

  logic                    r_vld_p2;
  logic [OUT_W-1:0]        r_out0_p2;
  logic                    r_zero_p2;
  logic                    r_multi_p2;

  // True when more than one group is non-empty.
  function automatic logic multi_grp(input logic [N_GRP-1:0] any);
    return |(any & (any - N_GRP'(1)));
  endfunction

  assign w_adv        = !r_vld_p2 || bus.out_ready;
  assign bus.in_ready = w_adv;
  assign w_word       = {bus.in1, bus.in0};

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    enc_grp u_grp (
      .i_bits (w_word[g*GRP_W +: GRP_W]),
      .o_res  (w_res[g])
    );
  end

  // ---- stage 1: per-group encode ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_any_p1  <= '0;
      r_mul_p1  <= '0;
      r_lidx_p1 <= '{default: '0};
    end else if (w_adv) begin
      r_vld_p1 <= bus.in_valid;
      for (int g = 0; g < N_GRP; g++) begin
        r_any_p1[g]  <= w_res[g].any;
        r_mul_p1[g]  <= w_res[g].mul;
        r_lidx_p1[g] <= w_res[g].lidx;
      end
    end
  end

  // Lowest non-empty group wins; defaults to group 0 when all are empty.
  always_comb begin
    w_gsel = '0;
    for (int g = N_GRP - 1; g >= 0; g--) begin
      if (r_any_p1[g]) w_gsel = GIDX_W'(g);
    end
  end

  assign w_zero  = ~|r_any_p1;
  assign w_multi = !w_zero && (r_mul_p1[w_gsel] || multi_grp(r_any_p1));
  assign w_out0  = w_zero ? '0 : {w_gsel, r_lidx_p1[w_gsel]};

  // ---- stage 2: group select and output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_out0_p2  <= '0;
      r_zero_p2  <= 1'b0;
      r_multi_p2 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p2   <= r_vld_p1;
      r_out0_p2  <= w_out0;
      r_zero_p2  <= w_zero;
      r_multi_p2 <= w_multi;
    end
  end

  assign bus.out_valid = r_vld_p2;
  assign bus.out0      = r_out0_p2;
  assign bus.zero      = r_zero_p2;
  assign bus.multi     = r_multi_p2;

endmodule
